// File: rtl/alzette_pkg.sv
// Shared definitions for the Alzette ARX-box datapaths (forward ISE and
// iterative inverse engine).
//   state_e          : sequencer states (IDLE, RUN, DONE)
//   alz_rcon()       : 8-entry round-constant table, indexed by 3-bit imm
//   inv_rot_s/_r()   : per-quarter rotate amounts, inverse order
//   fwd_rot_add/_xor : per-quarter rotate amounts, forward order
//   alz_rotr()       : 32-bit rotate right by a 5-bit amount
package alzette_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic [31:0] alz_rcon(input logic [2:0] idx);
        logic [31:0] c;
        case (idx)
            3'd0:    c = 32'hB7E1_5162;
            3'd1:    c = 32'hBF71_5880;
            3'd2:    c = 32'h38B4_DA56;
            3'd3:    c = 32'h324E_7738;
            3'd4:    c = 32'hBB11_85EB;
            3'd5:    c = 32'h4F7C_7B57;
            3'd6:    c = 32'hCFBF_A1C8;
            default: c = 32'hC2B3_293D;
        endcase
        return c;
    endfunction

    // Inverse quarter q: y ^= rotr(x, s_q); x -= rotr(y, r_q)
    function automatic logic [4:0] inv_rot_s(input logic [1:0] q);
        logic [4:0] s;
        case (q)
            2'd0:    s = 5'd16;
            2'd1:    s = 5'd31;
            2'd2:    s = 5'd17;
            default: s = 5'd24;
        endcase
        return s;
    endfunction

    function automatic logic [4:0] inv_rot_r(input logic [1:0] q);
        logic [4:0] r;
        case (q)
            2'd0:    r = 5'd24;
            2'd1:    r = 5'd0;
            2'd2:    r = 5'd17;
            default: r = 5'd31;
        endcase
        return r;
    endfunction

    // Forward quarter q: x += rotr(y, add_q); y ^= rotr(x, xor_q); x ^= c
    function automatic logic [4:0] fwd_rot_add(input logic [1:0] q);
        logic [4:0] r;
        case (q)
            2'd0:    r = 5'd31;
            2'd1:    r = 5'd17;
            2'd2:    r = 5'd0;
            default: r = 5'd24;
        endcase
        return r;
    endfunction

    function automatic logic [4:0] fwd_rot_xor(input logic [1:0] q);
        logic [4:0] s;
        case (q)
            2'd0:    s = 5'd24;
            2'd1:    s = 5'd17;
            2'd2:    s = 5'd31;
            default: s = 5'd16;
        endcase
        return s;
    endfunction

    // A left shift by 32 yields zero, so n == 0 returns v unchanged.
    function automatic logic [31:0] alz_rotr(input logic [31:0] v, input logic [4:0] n);
        return (v >> n) | (v << (6'd32 - {1'b0, n}));
    endfunction

endpackage

// File: rtl/alzette_inv_quarter.sv
// One inverse Alzette quarter-round, purely combinational.
//   x_i, y_i : current state halves
//   c_i      : round constant
//   s_i, r_i : rotate amounts for this quarter
//   x_o, y_o : state after the quarter
module alzette_inv_quarter
    import alzette_pkg::*;
(
    input  logic [31:0] x_i,
    input  logic [31:0] y_i,
    input  logic [31:0] c_i,
    input  logic [4:0]  s_i,
    input  logic [4:0]  r_i,
    output logic [31:0] x_o,
    output logic [31:0] y_o
);

    logic [31:0] x_t;
    logic [31:0] y_t;

    always_comb begin
        x_t = x_i ^ c_i;
        y_t = y_i ^ alz_rotr(x_t, s_i);
        // Modulo-2^32 subtract; the borrow is intentionally discarded.
        x_o = x_t - alz_rotr(y_t, r_i);
        y_o = y_t;
    end

endmodule

// File: rtl/alzette_inv_seq.sv
// Iterative inverse-Alzette engine: one quarter-round per cycle, four
// cycles per operation, full (x, y) result returned by valid/ready.
//   g_clk, g_resetn      : clock, synchronous active-low reset
//   flush                : abort any operation, back to IDLE next edge
//   in_valid/in_ready    : request handshake (in_ready high only in IDLE)
//   in_x, in_y, in_imm   : ciphertext-side state and constant index
//   out_valid/out_ready  : result handshake (result held until accepted)
//   out_x, out_y         : recovered state, driven straight from registers
module alzette_inv_seq
    import alzette_pkg::*;
(
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_x,
    input  logic [31:0] in_y,
    input  logic [2:0]  in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_x,
    output logic [31:0] out_y
);

    state_e      state_q, state_d;
    logic [1:0]  qc_q, qc_d;
    logic [31:0] x_q, x_d;
    logic [31:0] y_q, y_d;
    logic [31:0] c_q, c_d;

    logic [31:0] qx;
    logic [31:0] qy;
    logic        accept;

    alzette_inv_quarter u_quarter (
        .x_i (x_q),
        .y_i (y_q),
        .c_i (c_q),
        .s_i (inv_rot_s(qc_q)),
        .r_i (inv_rot_r(qc_q)),
        .x_o (qx),
        .y_o (qy)
    );

    // flush blocks the accept even when in_valid is high in IDLE.
    assign accept = (state_q == ST_IDLE) && in_valid && !flush;

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            state_q <= ST_IDLE;
            qc_q    <= 2'd0;
            x_q     <= 32'd0;
            y_q     <= 32'd0;
            c_q     <= 32'd0;
        end else begin
            state_q <= state_d;
            qc_q    <= qc_d;
            x_q     <= x_d;
            y_q     <= y_d;
            c_q     <= c_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (in_valid)     state_d = ST_RUN;
                ST_RUN:  if (qc_q == 2'd3) state_d = ST_DONE;
                ST_DONE: if (out_ready)    state_d = ST_IDLE;
                default:                   state_d = ST_IDLE;
            endcase
        end
    end

    // Datapath registers: load on accept, advance one quarter per RUN cycle,
    // hold otherwise (including DONE, which keeps the outputs stable).
    always_comb begin
        x_d  = x_q;
        y_d  = y_q;
        c_d  = c_q;
        qc_d = qc_q;
        if (accept) begin
            x_d  = in_x;
            y_d  = in_y;
            c_d  = alz_rcon(in_imm);
            qc_d = 2'd0;
        end else if (!flush && state_q == ST_RUN) begin
            x_d  = qx;
            y_d  = qy;
            qc_d = qc_q + 2'd1;
        end
    end

    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
        out_x     = x_q;
        out_y     = y_q;
    end

endmodule

// File: tb/tb_alzette_inv_seq.sv
module tb_alzette_inv_seq;

    logic        g_clk = 1'b0;
    logic        g_resetn;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_x;
    logic [31:0] in_y;
    logic [2:0]  in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_x;
    logic [31:0] out_y;

    int checks = 0;
    int errors = 0;
    logic [63:0] sb_q[$];

    alzette_inv_seq dut (
        .g_clk     (g_clk),
        .g_resetn  (g_resetn),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_x     (out_x),
        .out_y     (out_y)
    );

    always #5 g_clk = ~g_clk;

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] rcon(input int i);
        logic [31:0] t [8];
        t = '{32'hB7E15162, 32'hBF715880, 32'h38B4DA56, 32'h324E7738,
              32'hBB1185EB, 32'h4F7C7B57, 32'hCFBFA1C8, 32'hC2B3293D};
        return t[i];
    endfunction

    function automatic logic [31:0] rotr(input logic [31:0] v, input int n);
        if (n == 0) return v;
        return (v >> n) | (v << (32 - n));
    endfunction

    function automatic logic [63:0] fwd(input logic [31:0] xi, input logic [31:0] yi, input logic [31:0] c);
        logic [31:0] x, y;
        x = xi; y = yi;
        x = x + rotr(y, 31); y = y ^ rotr(x, 24); x = x ^ c;
        x = x + rotr(y, 17); y = y ^ rotr(x, 17); x = x ^ c;
        x = x + y;           y = y ^ rotr(x, 31); x = x ^ c;
        x = x + rotr(y, 24); y = y ^ rotr(x, 16); x = x ^ c;
        return {x, y};
    endfunction

    function automatic logic [63:0] inv(input logic [31:0] xi, input logic [31:0] yi, input logic [31:0] c);
        logic [31:0] x, y;
        x = xi; y = yi;
        x = x ^ c; y = y ^ rotr(x, 16); x = x - rotr(y, 24);
        x = x ^ c; y = y ^ rotr(x, 31); x = x - y;
        x = x ^ c; y = y ^ rotr(x, 17); x = x - rotr(y, 17);
        x = x ^ c; y = y ^ rotr(x, 24); x = x - rotr(y, 31);
        return {x, y};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic accept_op(input logic [31:0] x, input logic [31:0] y, input logic [2:0] imm);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(negedge g_clk);
            n++;
        end
        chk("in_ready_before_accept", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_x     = x;
        in_y     = y;
        in_imm   = imm;
        @(posedge g_clk);
        @(negedge g_clk);
        in_valid = 1'b0;
        in_x     = $urandom;
        in_y     = $urandom;
        in_imm   = 3'($urandom_range(0, 7));
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge g_clk);
            lat++;
        end
    endtask

    task automatic compare_result(input string tag);
        logic [63:0] exp;
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'(sb_q.size()), 64'd1);
        end else begin
            exp = sb_q.pop_front();
            chk(tag, {out_x, out_y}, exp);
        end
    endtask

    task automatic finish_op(input string tag);
        int lat;
        wait_valid(lat);
        chk({tag, "_latency"}, 64'(lat), 64'd4);
        compare_result(tag);
        out_ready = 1'b1;
        @(posedge g_clk);
        @(negedge g_clk);
        chk({tag, "_in_ready_after"}, 64'(in_ready), 64'd1);
        chk({tag, "_out_valid_after"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        logic [63:0] v;
        logic [63:0] held;
        int          lat;
        int          seen;
        logic [31:0] bx [4];
        logic [31:0] by [4];
        int          prev, acc, got;

        g_resetn  = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_x      = 32'd0;
        in_y      = 32'd0;
        in_imm    = 3'd0;
        out_ready = 1'b1;

        // Reset
        repeat (2) @(posedge g_clk);
        @(negedge g_clk);
        g_resetn = 1'b1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_xy", {out_x, out_y}, 64'd0);
        @(negedge g_clk);

        // Round trip from (0,0), imm 0
        v = fwd(32'd0, 32'd0, rcon(0));
        accept_op(v[63:32], v[31:0], 3'd0);
        sb_q.push_back(64'd0);
        finish_op("rt_zero");

        // Round trip for every imm
        for (int i = 0; i < 8; i++) begin
            v = fwd(32'hDEADBEEF, 32'h01234567, rcon(i));
            accept_op(v[63:32], v[31:0], 3'(i));
            sb_q.push_back({32'hDEADBEEF, 32'h01234567});
            finish_op($sformatf("rt_imm%0d", i));
        end

        // Borrow-wrap coverage
        for (int i = 0; i < 8; i++) begin
            accept_op(32'h00000000, 32'hFFFFFFFF, 3'(i));
            sb_q.push_back(inv(32'h00000000, 32'hFFFFFFFF, rcon(i)));
            finish_op($sformatf("wrap_imm%0d", i));
        end

        // Backpressure
        out_ready = 1'b0;
        v = fwd(32'h13579BDF, 32'h2468ACE0, rcon(5));
        accept_op(v[63:32], v[31:0], 3'd5);
        sb_q.push_back({32'h13579BDF, 32'h2468ACE0});
        wait_valid(lat);
        chk("bp_latency", 64'(lat), 64'd4);
        held = {out_x, out_y};
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1;
            in_x     = $urandom;
            in_y     = $urandom;
            @(negedge g_clk);
            chk("bp_hold_xy", {out_x, out_y}, held);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
        end
        in_valid = 1'b0;
        compare_result("bp_result");
        out_ready = 1'b1;
        @(posedge g_clk);
        @(negedge g_clk);
        chk("bp_in_ready_after", 64'(in_ready), 64'd1);
        chk("bp_out_valid_after", 64'(out_valid), 64'd0);

        // Flush mid-RUN
        accept_op(32'hCAFEF00D, 32'h8BADF00D, 3'd3);
        flush = 1'b1;
        @(negedge g_clk);
        flush = 1'b0;
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge g_clk);
            if (out_valid) seen++;
        end
        chk("flush_no_valid", 64'(seen), 64'd0);
        v = fwd(32'h0F0F0F0F, 32'hF0F0F0F0, rcon(7));
        accept_op(v[63:32], v[31:0], 3'd7);
        sb_q.push_back({32'h0F0F0F0F, 32'hF0F0F0F0});
        finish_op("post_flush");

        // Reset mid-operation
        accept_op(32'h11111111, 32'h22222222, 3'd1);
        @(negedge g_clk);
        g_resetn = 1'b0;
        @(negedge g_clk);
        g_resetn = 1'b1;
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_out_xy", {out_x, out_y}, 64'd0);

        // Back-to-back with continuous in_valid
        for (int i = 0; i < 4; i++) begin
            bx[i] = $urandom;
            by[i] = $urandom;
        end
        prev = -1; acc = 0; got = 0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int cyc = 0; cyc < 100 && got < 4; cyc++) begin
            if (cyc > 0) @(negedge g_clk);
            if (out_valid) begin
                compare_result($sformatf("b2b_result%0d", got));
                got++;
            end
            if (in_ready && acc < 4) begin
                v = fwd(bx[acc], by[acc], rcon(acc + 2));
                in_x   = v[63:32];
                in_y   = v[31:0];
                in_imm = 3'(acc + 2);
                sb_q.push_back({bx[acc], by[acc]});
                if (prev >= 0) chk("b2b_spacing", 64'(cyc - prev), 64'd6);
                prev = cyc;
                acc++;
            end else if (acc < 4) begin
                in_x   = $urandom;
                in_y   = $urandom;
                in_imm = 3'($urandom_range(0, 7));
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        chk("b2b_count", 64'(got), 64'd4);
        chk("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alzette_inv_seq.md
# alzette_inv_seq

Iterative inverse-Alzette (ARX-box decryption) engine: accepts a 64-bit (x, y) state and a 3-bit constant index, and applies the four inverse Alzette quarter-rounds, one per cycle. It returns both halves together through a valid/ready handshake. It sits beside the single-cycle Alzette ISE datapath as a decoupled decrypt-direction unit, for use by a memory-mapped or coprocessor port that needs the full (x, y) result in one transaction.

## Interface
- No parameters; all widths fixed at 32-bit words.
- g_clk  in  1  clock; all state updates on rising edge
- g_resetn  in  1  synchronous, active-low reset
- flush  in  1  abort any in-flight operation; return to IDLE next edge
- in_valid  in  1  request valid
- in_ready  out  1  high only in IDLE
- in_x  in  32  ciphertext-side x
- in_y  in  32  ciphertext-side y
- in_imm  in  3  round-constant index 0..7
- out_valid  out  1  result valid; held until accepted
- out_ready  in  1  consumer accepts result
- out_x  out  32  recovered x
- out_y  out  32  recovered y

## Operation
- Constant table, indexed by imm: 0 B7E15162, 1 BF715880, 2 38B4DA56, 3 324E7738, 4 BB1185EB, 5 4F7C7B57, 6 CFBFA1C8, 7 C2B3293D.
- The constant is latched at accept and stays fixed for the operation.
- rotr(v,n) denotes a 32-bit rotate right.
- Each quarter q applies three steps in order, all inside one cycle:
  - x' = x ^ c
  - y' = y ^ rotr(x', s_q)
  - x'' = x' - rotr(y', r_q)
- Arithmetic is modulo 2^32 and wraps silently. There is no carry or borrow output.
- Rotation pairs (s_q, r_q): q0 (16,24), q1 (31,0), q2 (17,17), q3 (24,31).
- After q3, the state is the exact inverse of one forward Alzette with the same constant.
- FSM states:
  - IDLE: in_ready=1. When in_valid=1, latch x, y and c, clear quarter counter qc, go to RUN.
  - RUN: apply quarter qc; qc++. When qc==3, go to DONE.
  - DONE: out_valid=1. When out_ready=1, go to IDLE.
- qc is 2 bits. It wraps only on the qc==3 transition and is never observed outside RUN.
- flush=1 in any state forces IDLE on the next edge and discards the result; out_valid drops. flush has priority over in_valid and out_ready.
- When in_valid and flush are both high in IDLE, no accept occurs.
- in_x, in_y and in_imm are sampled only on the accept edge. Changes afterwards have no effect.
- out_x and out_y are registers. They are stable for as long as out_valid=1.

## Timing
- Reset (g_resetn=0 at an edge): state IDLE, qc=0, x/y/c registers 0. Outputs: in_ready=1, out_valid=0, out_x=0, out_y=0.
- Reset mid-operation aborts the operation identically to flush.
- Accept at edge E0. Quarters complete at E1..E4. out_valid rises after E4, i.e. 4 cycles of latency from accept.
- With out_ready held high: result consumed at E5, in_ready high after E5, next accept possible at E6. Peak throughput is one operation per 6 cycles.
- Backpressure: out_valid stays high and outputs hold indefinitely while out_ready=0.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid. All outputs come from registers or decode the FSM state.
- Critical path per cycle: one 32-bit XOR, one XOR, one 32-bit subtract, plus a rotate mux on qc.

## Structure
- Shared package `alzette_pkg`:
  - 8-entry constant table and lookup function
  - rotation-amount constants for the forward and inverse quarter order
  - FSM state enum (IDLE, RUN, DONE)
- This same package is reused by the forward ISE datapath.
- One natural sub-module, `alzette_inv_quarter`: combinational x, y, c, s, r → x'', y''. Rotate amounts are selected by qc in the parent.
- The parent holds the FSM, the qc counter, the state registers and the handshake logic.

## Test plan
- Reset then idle: g_resetn low for 2 cycles → in_ready=1, out_valid=0, out_x=out_y=0.
- Round trip: drive (x=0, y=0, imm=0) through the forward Alzette reference model to get (X, Y). Submit (X, Y, imm=0) → out_valid exactly 4 cycles after accept, (out_x, out_y)=(0,0). Repeat for all imm 0..7 with x=DEADBEEF, y=01234567.
- Wrap coverage: inputs X=00000000, Y=FFFFFFFF for each imm → result matches the golden model bit-exactly, including subtract borrow wrap.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid → outputs constant, in_ready=0, new in_valid ignored. Release → consumed, in_ready=1 next cycle.
- Flush mid-RUN: accept, then assert flush at cycle 2 → next cycle IDLE, out_valid never rises. Next request completes normally with correct result.
- Back-to-back with out_ready=1 and in_valid=1 continuously → accepts spaced exactly 6 cycles apart, all results correct. Input changes during RUN do not affect results.
